// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one line-granular main memory between the I-cache
// (port 0) and the D-cache (port 1). One transaction is in flight at a time.
// The owner is picked in IDLE, and its request is latched and forwarded to
// memory. The completion pulse is routed back to the owner only. Read lines
// are held in a buffer for each port.
// Build option: MEM_ARB_FIXED_PRIO_EN makes port 0 win every tie. Port 1 can
// then starve. When the option is not defined, ties are broken round-robin.
module mem_arbiter #(
    parameter int LINE_ADDR_LEN = 3,
    parameter int ADDR_LEN      = 9,
    parameter int CNT_W         = 32,
    localparam int LINE_SIZE    = 1 << LINE_ADDR_LEN,
    localparam int LINE_W       = 32 * LINE_SIZE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rd_req0,
    input  logic                wr_req0,
    input  logic [ADDR_LEN-1:0] addr0,
    input  logic [LINE_W-1:0]   wr_line0,
    input  logic                rd_req1,
    input  logic                wr_req1,
    input  logic [ADDR_LEN-1:0] addr1,
    input  logic [LINE_W-1:0]   wr_line1,
    output logic                gnt0,
    output logic                gnt1,
    output logic [LINE_W-1:0]   rd_line0,
    output logic [LINE_W-1:0]   rd_line1,
    output logic                mem_rd_req,
    output logic                mem_wr_req,
    output logic [ADDR_LEN-1:0] mem_addr,
    output logic [LINE_W-1:0]   mem_wr_line,
    input  logic [LINE_W-1:0]   mem_rd_line,
    input  logic                mem_gnt,
    output logic [CNT_W-1:0]    grant_cnt0,
    output logic [CNT_W-1:0]    grant_cnt1
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state_q, state_d;
    logic                owner_q, owner_d;
    logic                last_owner_q, last_owner_d;
    logic                op_wr_q, op_wr_d;
    logic                mem_rd_req_q, mem_rd_req_d;
    logic                mem_wr_req_q, mem_wr_req_d;
    logic [ADDR_LEN-1:0] addr_q, addr_d;
    logic [LINE_W-1:0]   wline_q, wline_d;
    logic [LINE_W-1:0]   rd_line0_q, rd_line0_d;
    logic [LINE_W-1:0]   rd_line1_q, rd_line1_d;
    logic [CNT_W-1:0]    cnt0_q, cnt0_d;
    logic [CNT_W-1:0]    cnt1_q, cnt1_d;

    logic pend0, pend1, tie_win, win, win_wr;

    assign pend0 = rd_req0 | wr_req0;
    assign pend1 = rd_req1 | wr_req1;

`ifdef MEM_ARB_FIXED_PRIO_EN
    assign tie_win = 1'b0;
`else
    assign tie_win = ~last_owner_q;
`endif

    // A lone requester wins. On a tie, tie_win chooses the port.
    // A write request takes priority over a read from the same port, so the
    // write-back happens before the refill.
    assign win    = (pend0 & pend1) ? tie_win : pend1;
    assign win_wr = win ? wr_req1 : wr_req0;

    // Next-state logic: arbitrate in IDLE. In BUSY, wait for mem_gnt and then
    // retire the transaction to its owner.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        op_wr_d      = op_wr_q;
        mem_rd_req_d = mem_rd_req_q;
        mem_wr_req_d = mem_wr_req_q;
        addr_d       = addr_q;
        wline_d      = wline_q;
        rd_line0_d   = rd_line0_q;
        rd_line1_d   = rd_line1_q;
        cnt0_d       = cnt0_q;
        cnt1_d       = cnt1_q;
        gnt0         = 1'b0;
        gnt1         = 1'b0;
        case (state_q)
            IDLE: begin
                if (pend0 | pend1) begin
                    owner_d      = win;
                    op_wr_d      = win_wr;
                    addr_d       = win ? addr1 : addr0;
                    wline_d      = win ? wr_line1 : wr_line0;
                    mem_rd_req_d = ~win_wr;
                    mem_wr_req_d = win_wr;
                    state_d      = BUSY;
                end
            end
            BUSY: begin
                if (mem_gnt) begin
                    if (owner_q) begin
                        gnt1   = 1'b1;
                        cnt1_d = cnt1_q + CNT_W'(1);
                        if (!op_wr_q) rd_line1_d = mem_rd_line;
                    end else begin
                        gnt0   = 1'b1;
                        cnt0_d = cnt0_q + CNT_W'(1);
                        if (!op_wr_q) rd_line0_d = mem_rd_line;
                    end
                    last_owner_d = owner_q;
                    mem_rd_req_d = 1'b0;
                    mem_wr_req_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register. Reset abandons any in-flight transaction right away.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            op_wr_q      <= 1'b0;
            mem_rd_req_q <= 1'b0;
            mem_wr_req_q <= 1'b0;
            addr_q       <= '0;
            wline_q      <= '0;
            rd_line0_q   <= '0;
            rd_line1_q   <= '0;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            op_wr_q      <= op_wr_d;
            mem_rd_req_q <= mem_rd_req_d;
            mem_wr_req_q <= mem_wr_req_d;
            addr_q       <= addr_d;
            wline_q      <= wline_d;
            rd_line0_q   <= rd_line0_d;
            rd_line1_q   <= rd_line1_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
        end
    end

    assign mem_rd_req  = mem_rd_req_q;
    assign mem_wr_req  = mem_wr_req_q;
    assign mem_addr    = addr_q;
    assign mem_wr_line = wline_q;
    assign rd_line0    = rd_line0_q;
    assign rd_line1    = rd_line1_q;
    assign grant_cnt0  = cnt0_q;
    assign grant_cnt1  = cnt1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus for mem_arbiter.
// Each request pushes its expected grant into a queue. A negedge monitor pops
// that entry on every gnt and checks the memory-side view, the read-line
// buffers and the counters of both ports.
`timescale 1ns/1ps
module tb_mem_arbiter;
    localparam int AW = 9;
    localparam int LW = 256;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          rd_req0, wr_req0, rd_req1, wr_req1;
    logic [AW-1:0] addr0, addr1;
    logic [LW-1:0] wr_line0, wr_line1;
    logic          gnt0, gnt1;
    logic [LW-1:0] rd_line0, rd_line1;
    logic          mem_rd_req, mem_wr_req;
    logic [AW-1:0] mem_addr;
    logic [LW-1:0] mem_wr_line, mem_rd_line;
    logic          mem_gnt;
    logic [CW-1:0] grant_cnt0, grant_cnt1;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .rd_req0(rd_req0), .wr_req0(wr_req0), .addr0(addr0), .wr_line0(wr_line0),
        .rd_req1(rd_req1), .wr_req1(wr_req1), .addr1(addr1), .wr_line1(wr_line1),
        .gnt0(gnt0), .gnt1(gnt1), .rd_line0(rd_line0), .rd_line1(rd_line1),
        .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr),
        .mem_wr_line(mem_wr_line), .mem_rd_line(mem_rd_line), .mem_gnt(mem_gnt),
        .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            port;
        bit            wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] wline;
    } exp_t;

    exp_t exp_q[$];
    int   nvec = 0;
    int   errs = 0;
    int   lat  = 3;

    localparam logic [LW-1:0] DEAD = {8{32'hDEADBEEF}};

    // Memory contents: word i of line a is {a ^ 5, 0xA0 + i}. Line 0x05
    // therefore holds 0xA0..0xA7.
    function automatic logic [LW-1:0] line_for(input logic [AW-1:0] a);
        logic [LW-1:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = {15'd0, a ^ 9'h005, 8'(8'hA0 + i)};
        return l;
    endfunction

    assign mem_rd_line = line_for(mem_addr);

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        nvec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        nvec++;
        errs++;
        $display("FAIL %s", nm);
    endtask

    // Memory model: pulses mem_gnt for one cycle, lat cycles after a request
    // is first seen.
    initial begin
        int c;
        c = 0;
        mem_gnt = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_gnt) begin
                mem_gnt = 1'b0;
                c = 0;
            end else if (mem_rd_req | mem_wr_req) begin
                c++;
                if (c >= lat) mem_gnt = 1'b1;
            end else c = 0;
        end
    end

    // Scoreboard monitor. It keeps its own model of the read buffers and counters.
    logic [LW-1:0] m_rl[2];
    logic [CW-1:0] m_cnt[2];
    bit            post;
    initial begin
        exp_t e;
        m_rl[0] = '0; m_rl[1] = '0; m_cnt[0] = '0; m_cnt[1] = '0; post = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_rl[0] = '0; m_rl[1] = '0; m_cnt[0] = '0; m_cnt[1] = '0; post = 0;
            end else begin
                if (post) begin
                    chk("rd_line0", rd_line0, m_rl[0]);
                    chk("rd_line1", rd_line1, m_rl[1]);
                    chk("grant_cnt0", grant_cnt0, m_cnt[0]);
                    chk("grant_cnt1", grant_cnt1, m_cnt[1]);
                    post = 0;
                end
                if (gnt0 | gnt1) begin
                    if (gnt0 & gnt1) fail("both gnt high");
                    if (exp_q.size() == 0) fail("unexpected gnt");
                    else begin
                        e = exp_q.pop_front();
                        chk("gnt port", LW'(gnt1), LW'(e.port));
                        chk("mem_addr at gnt", LW'(mem_addr), LW'(e.addr));
                        chk("mem_wr_req at gnt", LW'(mem_wr_req), LW'(e.wr));
                        chk("mem_rd_req at gnt", LW'(mem_rd_req), LW'(!e.wr));
                        if (e.wr) chk("mem_wr_line", mem_wr_line, e.wline);
                        else m_rl[e.port] = line_for(e.addr);
                        m_cnt[e.port] = m_cnt[e.port] + 1;
                        post = 1;
                    end
                end
            end
        end
    end

    task automatic drive(input int p, input bit rd, input bit wr, input logic [AW-1:0] a,
                         input logic [LW-1:0] wl);
        if (p == 0) begin rd_req0 = rd; wr_req0 = wr; addr0 = a; wr_line0 = wl; end
        else        begin rd_req1 = rd; wr_req1 = wr; addr1 = a; wr_line1 = wl; end
    endtask

    task automatic wait_gnt(input int p);
        bit ok;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if ((p == 0) ? gnt0 : gnt1) begin ok = 1; break; end
        end
        if (!ok) fail($sformatf("timeout waiting gnt%0d", p));
    endtask

    // n back-to-back requests from one port. The next request is raised in
    // the cycle right after each gnt, as a cache re-requesting would.
    task automatic seq(input int p, input int n, input logic [AW-1:0] base, input bit wr,
                       input logic [LW-1:0] wl);
        for (int k = 0; k < n; k++) begin
            drive(p, 1'b1, wr, base + AW'(k), wl);
            wait_gnt(p);
            @(posedge clk); #1;
        end
        drive(p, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic push(input int p, input bit wr, input logic [AW-1:0] a, input logic [LW-1:0] wl);
        exp_t e;
        e.port = p; e.wr = wr; e.addr = a; e.wline = wl;
        exp_q.push_back(e);
    endtask

    initial begin
        #200000;
        fail("watchdog");
        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, '0, '0);
        drive(1, 0, 0, '0, '0);
        #12;
        chk("reset mem_rd_req", LW'(mem_rd_req), '0);
        chk("reset mem_wr_req", LW'(mem_wr_req), '0);
        chk("reset mem_addr", LW'(mem_addr), '0);
        chk("reset mem_wr_line", mem_wr_line, '0);
        chk("reset rd_line0", rd_line0, '0);
        chk("reset rd_line1", rd_line1, '0);
        chk("reset gnt", LW'({gnt0, gnt1}), '0);
        chk("reset counters", LW'({grant_cnt0, grant_cnt1}), '0);
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1;

        // Both ports request together after reset. Port 0 is served first,
        // and port 1's address reaches memory at G+2.
        push(0, 0, 9'h010, '0);
        push(1, 0, 9'h020, '0);
        fork
            seq(0, 1, 9'h010, 0, '0);
            seq(1, 1, 9'h020, 0, '0);
            begin
                wait_gnt(0);
                @(negedge clk); @(negedge clk);
                chk("p1 mem_addr at G+2", LW'(mem_addr), LW'(9'h020));
                chk("p1 mem_rd_req at G+2", LW'(mem_rd_req), LW'(1'b1));
            end
        join

        // Port 0 reads 0x05. The request appears at T+1, and an address change
        // while BUSY is ignored.
        @(posedge clk); #1;
        push(0, 0, 9'h005, '0);
        drive(0, 1, 0, 9'h005, '0);
        @(negedge clk);
        chk("mem_rd_req in arb cycle", LW'(mem_rd_req), '0);
        @(negedge clk);
        chk("mem_rd_req at T+1", LW'(mem_rd_req), LW'(1'b1));
        chk("mem_addr at T+1", LW'(mem_addr), LW'(9'h005));
        #2 addr0 = 9'h006;
        begin
            bit seen;
            seen = 0;
            for (int i = 0; i < 50 && !seen; i++) begin
                @(negedge clk);
                chk("mem_addr held", LW'(mem_addr), LW'(9'h005));
                chk("gnt1 idle", LW'(gnt1), '0);
                seen = gnt0;
            end
            if (!seen) fail("timeout gnt0 addr-change");
        end
        @(posedge clk); #1;
        drive(0, 0, 0, '0, '0);
        @(negedge clk);
        chk("mem_rd_req low at G+1", LW'(mem_rd_req), '0);
        chk("rd_line0 A0..A7", rd_line0, {32'hA7, 32'hA6, 32'hA5, 32'hA4,
                                          32'hA3, 32'hA2, 32'hA1, 32'hA0});

        // Port 1 raises read and write together. The write is performed, and
        // its read buffer is left untouched.
        @(posedge clk); #1;
        push(1, 1, 9'h033, DEAD);
        seq(1, 1, 9'h033, 1, DEAD);

        // Port 1 keeps requesting, and port 0 re-requests after every grant.
`ifdef MEM_ARB_FIXED_PRIO_EN
        push(0, 0, 9'h040, '0); push(0, 0, 9'h041, '0); push(0, 0, 9'h042, '0);
        push(1, 0, 9'h050, '0); push(1, 0, 9'h051, '0);
`else
        push(0, 0, 9'h040, '0); push(1, 0, 9'h050, '0); push(0, 0, 9'h041, '0);
        push(1, 0, 9'h051, '0); push(0, 0, 9'h042, '0);
`endif
        @(posedge clk); #1;
        fork
            seq(0, 3, 9'h040, 0, '0);
            seq(1, 2, 9'h050, 0, '0);
        join

        // Reset arrives mid-transaction. The requests drop at once, and the
        // transaction is abandoned without a gnt.
        lat = 50;
        @(posedge clk); #1;
        drive(0, 1, 0, 9'h070, '0);
        @(negedge clk); @(negedge clk);
        chk("busy before reset", LW'(mem_rd_req), LW'(1'b1));
        #2 rst = 1'b1;
        #1;
        chk("async drop mem_rd_req", LW'(mem_rd_req), '0);
        chk("async drop mem_wr_req", LW'(mem_wr_req), '0);
        chk("no gnt on reset", LW'({gnt0, gnt1}), '0);
        chk("counters cleared", LW'({grant_cnt0, grant_cnt1}), '0);
        drive(0, 0, 0, '0, '0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        lat = 3;
        @(posedge clk); #1;
        push(0, 0, 9'h011, '0);
        push(1, 0, 9'h022, '0);
        fork
            seq(0, 1, 9'h011, 0, '0);
            seq(1, 1, 9'h022, 0, '0);
        join

        @(negedge clk); @(negedge clk); @(negedge clk);
        chk("scoreboard drained", LW'(exp_q.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single line-granular `main_mem` between the instruction cache (port 0) and the data cache (port 1). Each cache presents its usual swap-in/swap-out request (`rd_req`/`wr_req`, line address, write line) and waits for `gnt`. The arbiter selects one owner with round-robin priority, latches that request and forwards it to memory. It returns the memory handshake only to the owner and buffers the read line per port. It sits between the two cache instances and `main_mem` in the top-level memory hierarchy.

## Interface
- `LINE_ADDR_LEN`, default 3: log2 of words per line; `LINE_SIZE = 1 << LINE_ADDR_LEN`.
- `ADDR_LEN`, default 9: memory line-address width (tag + set).
- `CNT_W`, default 32: width of the per-port grant counters.
- Reset `rst`, asynchronous, active-high; clock `clk`.
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous active-high reset.
- `rd_req0` / `rd_req1`  in  1  line read (swap-in) request; level, held until gnt.
- `wr_req0` / `wr_req1`  in  1  line write (swap-out) request; level, held until gnt.
- `addr0` / `addr1`  in  ADDR_LEN  line address.
- `wr_line0` / `wr_line1`  in  32 x LINE_SIZE  write data line.
- `gnt0` / `gnt1`  out  1  one-cycle completion pulse to that port.
- `rd_line0` / `rd_line1`  out  32 x LINE_SIZE  registered read line for that port.
- `mem_rd_req`  out  1  registered read request to `main_mem`.
- `mem_wr_req`  out  1  registered write request to `main_mem`.
- `mem_addr`  out  ADDR_LEN  latched address.
- `mem_wr_line`  out  32 x LINE_SIZE  latched write line.
- `mem_rd_line`  in  32 x LINE_SIZE  memory read line.
- `mem_gnt`  in  1  memory completion pulse.
- `grant_cnt0` / `grant_cnt1`  out  CNT_W  completed transactions per port; wraps modulo 2^CNT_W.

## Operation
- The block has two states, IDLE and BUSY.
- Registers: `owner` (1 bit), `last_owner` (1 bit), `op_wr` (1 bit), latched address and line, both read-line buffers, both counters.
- A port is pending when `rd_req | wr_req`.
- IDLE, one port pending: that port wins.
- IDLE, both ports pending: the port that is not `last_owner` wins.
- On a win, latch owner, address, `wr_line` and `op_wr = wr_req`, then go to BUSY.
- A port with both `rd_req` and `wr_req` high is treated as a write; the write-back precedes the refill.
- BUSY: `mem_wr_req = op_wr`, `mem_rd_req = ~op_wr`. Port inputs are ignored; address or data changes mid-transaction have no effect.
- BUSY, `mem_gnt` high:
  - `gnt<owner> = 1` combinationally in that cycle.
  - If `~op_wr`, `rd_line<owner>` captures `mem_rd_line` at that edge.
  - `grant_cnt<owner>` increments.
  - `last_owner <= owner`; go to IDLE.
- `rd_line<p>` holds its value until that port's next read grant; the other port's traffic never alters it.
- `gnt` is never asserted in IDLE. `mem_gnt` seen in IDLE is ignored.
- Reset values: state IDLE, `last_owner = 1` (port 0 wins the first tie), `mem_rd_req = mem_wr_req = 0`, `mem_addr = 0`, `mem_wr_line = 0`, `rd_line0 = rd_line1 = 0`, `gnt = 0`, counters 0.
- Reset mid-BUSY: memory requests drop immediately (asynchronous), no `gnt` is issued, and the transaction is abandoned.

## Timing
- Request first seen in IDLE at cycle T: BUSY and memory request high from T+1, with address and line valid from T+1.
- `mem_gnt` at cycle G: `gnt<owner>` in G; IDLE and memory requests low at G+1; `rd_line<owner>` valid at G+1, which is the caches' SWAP_IN_OK cycle.
- Back-to-back: the next transaction's memory request rises at G+2 at the earliest, so there is one idle cycle between transactions.
- Added latency versus a direct connection: exactly 1 cycle per transaction (the arbitration cycle).
- A cache going SWAP_OUT→SWAP_IN re-arbitrates; under contention the other port is served in between.

## Configuration
- `MEM_ARB_FIXED_PRIO_EN`
  - Defined: port 0 always wins when both ports are pending, regardless of `last_owner`. Instruction fetch is never delayed by more than one in-flight transaction, and port 1 may starve.
  - Undefined (default): round-robin as described in Operation.
- All other behaviour, including the counters, is identical in both builds.

## Test plan
- Port 0 read, `addr0=0x05`, memory returns line of words 0xA0..0xA7, `mem_gnt` 3 cycles after request → `mem_rd_req` high from T+1 with `mem_addr=0x05`; `gnt0` coincident with `mem_gnt`; `rd_line0` = 0xA0..0xA7 at G+1; `gnt1` never; `grant_cnt0=1`.
- After reset, simultaneous reads port 0 `0x10` and port 1 `0x20` → port 0 served first; `mem_addr=0x20` at G+2; `rd_line0` unchanged after port 1 completes.
- Port 1 requesting continuously with port 0 re-requesting after each grant → grants alternate 0,1,0,1; with `MEM_ARB_FIXED_PRIO_EN`, port 0 is granted every time.
- Port 1 with `wr_req1=rd_req1=1`, `addr1=0x33`, `wr_line1` all 0xDEADBEEF → `mem_wr_req=1`, `mem_wr_line` all 0xDEADBEEF; `rd_line1` unchanged after `gnt1`.
- Change `addr0` from 0x05 to 0x06 during BUSY → `mem_addr` stays 0x05 until `gnt0`.
- Assert `rst` mid-BUSY → memory requests 0 without waiting for a clock edge; no `gnt`; counters 0; the first tie after release goes to port 0.
